// File: rtl/req_line_encoder_if.sv
// ----------------------------------------------------------------------------
// req_line_encoder_if
// Groups the request-line encoder's request/handshake signals.
//   E_n      capture enable, active low            (producer -> encoder)
//   D_n      active-low request lines [0:3]        (producer -> encoder)
//   ready    consumer accepts current code         (consumer -> encoder)
//   ovr_clr  single-cycle clear of the overrun flag (consumer -> encoder)
//   A, B     encoded line number, A = MSB          (encoder -> consumer)
//   valid    {A,B} holds a pending event           (encoder -> consumer)
//   pend     pending-event register [0:3]          (encoder -> consumer)
//   ovr      sticky overrun flag                   (encoder -> consumer)
// Modports: master = environment driving requests, slave = the encoder.
// ----------------------------------------------------------------------------
interface req_line_encoder_if;
    logic       E_n;
    logic [0:3] D_n;
    logic       ready;
    logic       ovr_clr;
    logic       A;
    logic       B;
    logic       valid;
    logic [0:3] pend;
    logic       ovr;

    modport master (
        output E_n, D_n, ready, ovr_clr,
        input  A, B, valid, pend, ovr
    );

    modport slave (
        input  E_n, D_n, ready, ovr_clr,
        output A, B, valid, pend, ovr
    );
endinterface

// File: rtl/req_line_encoder.sv
// ----------------------------------------------------------------------------
// req_line_encoder
// Captures falling edges on four active-low request lines and presents them,
// one per accepted transfer, as a 2-bit code {A,B} (line0=00 .. line3=11) with
// a valid/ready handshake. Events are held as sticky pending bits.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   req_line_encoder_if.slave (E_n, D_n, ready, ovr_clr in;
//         A, B, valid, pend, ovr out)
//
// Parameters:
//   SYNC_STAGES  input synchroniser depth on D_n (0..3, 0 = sampled directly)
//
// Build option:
//   ROUND_ROBIN_EN  defined   -> winner is the first pending line searching
//                                upward from last-granted+1 (last resets to 3)
//                   undefined -> fixed priority, line0 highest
//
// States:
//   IDLE    | nothing presented, waiting for a pending bit
//   PRESENT | {A,B} valid, held until the consumer accepts
// ----------------------------------------------------------------------------
module req_line_encoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    req_line_encoder_if.slave    bus
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t     state;
    logic [0:3] d_s;
    logic [0:3] hist;
    logic [0:3] ev;
    logic [0:3] win_oh;
    logic [0:3] clr;
    logic [0:3] pend_nxt;
    logic [0:3] ovf;
    logic [0:3] sel_src;
    logic [1:0] nxt_code;
    logic       accept;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign d_s = bus.D_n;
        end else begin : g_sync
            logic [0:3] sync_r [SYNC_STAGES];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= '1;
                end else begin
                    sync_r[0] <= bus.D_n;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
                end
            end
            assign d_s = sync_r[SYNC_STAGES-1];
        end
    endgenerate

`ifdef ROUND_ROBIN_EN
    logic [1:0] last;

    function automatic logic [1:0] pick(input logic [0:3] p, input logic [1:0] from);
        logic [1:0] idx;
        logic       found;
        pick  = from;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = from + 2'(k);
            if (!found && p[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction
`else
    function automatic logic [1:0] pick(input logic [0:3] p);
        pick = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (p[k]) pick = 2'(k);
        end
    endfunction
`endif

    always_comb begin
        // {A,B} doubles as the frozen winner index while presenting
        win_oh = '0;
        win_oh[{bus.A, bus.B}] = 1'b1;
        accept   = bus.valid & bus.ready;
        ev       = hist & ~d_s & {4{~bus.E_n}};
        clr      = accept ? win_oh : 4'b0000;
        // a fresh edge on the line being accepted keeps it pending
        pend_nxt = (bus.pend & ~clr) | ev;
        ovf      = ev & bus.pend & ~clr;
        // back-to-back reload selects from what remains after this edge
        sel_src  = (state == IDLE) ? bus.pend : pend_nxt;
`ifdef ROUND_ROBIN_EN
        nxt_code = pick(sel_src, last);
`else
        nxt_code = pick(sel_src);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hist      <= '1;
            bus.pend  <= '0;
            bus.A     <= 1'b0;
            bus.B     <= 1'b0;
            bus.valid <= 1'b0;
            bus.ovr   <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last      <= 2'd3;
`endif
        end else begin
            hist     <= d_s;
            bus.pend <= pend_nxt;
            // overrun has priority over the clear pulse
            bus.ovr  <= (|ovf) | (bus.ovr & ~bus.ovr_clr);
            case (state)
                IDLE: begin
                    if (|bus.pend) begin
                        {bus.A, bus.B} <= nxt_code;
                        bus.valid      <= 1'b1;
                        state          <= PRESENT;
`ifdef ROUND_ROBIN_EN
                        last           <= nxt_code;
`endif
                    end
                end
                PRESENT: begin
                    if (bus.ready) begin
                        if (|pend_nxt) begin
                            {bus.A, bus.B} <= nxt_code;
`ifdef ROUND_ROBIN_EN
                            last           <= nxt_code;
`endif
                        end else begin
                            bus.valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
